// File: rtl/irrig_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irrig_pkg
//  Purpose  : Shared types and helpers for the irrigation sequencer.
//             Holds the sequencer state encoding, the area index type and
//             small constant helpers used for sizing.
//  Revision : 1.0  initial release
// ============================================================================
package irrig_pkg;

    // Number of independently valved irrigation areas.
    localparam int N_AREAS = 2;

    // Index of one irrigation area.
    typedef logic area_t;

    // Sequencer states. IDLE must stay at zero so reset lands there.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_WATER = 3'd2,
        ST_CLOSE = 3'd3,
        ST_REST  = 3'd4
    } irrig_state_t;

    // Largest of three integers. Sizes the shared phase timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One-hot valve pattern for a given area.
    function automatic logic [N_AREAS-1:0] area_onehot(input area_t a);
        logic [N_AREAS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage : irrig_pkg
`default_nettype wire

// File: rtl/irrig_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module   : irrig_tick_timer
//  Purpose  : Loadable down-counter advanced by the slow tick strobe.
//             o_done pulses on a tick that arrives while the count is zero,
//             which is the edge where the owning phase ends. A load always
//             wins over a coincident tick, so the tick on the load edge
//             never counts toward the newly started phase.
//  Revision : 1.0  initial release
// ============================================================================
module irrig_tick_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_tick,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    // Count down once per tick, saturating at zero; reload on phase entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = i_tick && (r_count == '0);

endmodule : irrig_tick_timer
`default_nettype wire

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : irrigation_sequencer
//  Purpose  : Waters at most one area at a time with the timed sequence
//             PRIME (valve open) -> WATER (valve + pump) -> CLOSE (valve,
//             pump off) -> REST (all off) -> IDLE. Two simultaneously dry
//             areas are served round-robin. dry is only looked at in IDLE,
//             so a started dose always runs to completion.
//  Options  : IRRIG_FAULT_EN - per-area consecutive-dose counters; an area
//             dosed MAX_DOSES times in a row without ever reading not-dry
//             latches its fault bit and is masked from selection.
//  Revision : 1.0  initial release
// ============================================================================
module irrigation_sequencer
    import irrig_pkg::*;
#(
    parameter int PRIME_TICKS = 2,
    parameter int WATER_TICKS = 5,
    parameter int REST_TICKS  = 3,
    parameter int MAX_DOSES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [N_AREAS-1:0] dry,
    output logic [N_AREAS-1:0] valve,
    output logic               pump,
    output logic               busy,
    output area_t              area,
    output logic [N_AREAS-1:0] fault
);

    // One timer is shared by every timed phase, so it is sized for the
    // longest of them.
    localparam int c_TMR_W = $clog2(max3(PRIME_TICKS, WATER_TICKS, REST_TICKS) + 1);

    // Timer reload values: a phase of N ticks ends on the tick that finds
    // the counter at zero, so it is loaded with N-1.
    localparam logic [c_TMR_W-1:0] c_PRIME_LD = c_TMR_W'(PRIME_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_WATER_LD = c_TMR_W'(WATER_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_CLOSE_LD = '0;
    localparam logic [c_TMR_W-1:0] c_REST_LD  = c_TMR_W'(REST_TICKS - 1);

    irrig_state_t       r_state;
    logic [N_AREAS-1:0] r_valve;
    logic               r_pump;
    logic               r_busy;
    area_t              r_area;
    area_t              r_last_served;

    logic [N_AREAS-1:0] w_fault;
    logic [N_AREAS-1:0] w_elig;
    logic               w_sel_valid;
    area_t              w_sel;
    logic               w_done;
    logic               w_load;
    logic [c_TMR_W-1:0] w_load_val;

    // Pick the area to serve from the eligible dry flags; a tie goes to the
    // area that was not served last.
    always_comb begin
        w_sel_valid = (w_elig != '0);
        w_sel       = 1'b0;
        case (w_elig)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            2'b11:   w_sel = ~r_last_served;
            default: w_sel = 1'b0;
        endcase
    end

    // Reload the shared timer on every phase entry with that phase's length.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_load     = 1'b1;
                    w_load_val = c_PRIME_LD;
                end
            end
            ST_PRIME: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = c_WATER_LD;
                end
            end
            ST_WATER: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = c_CLOSE_LD;
                end
            end
            ST_CLOSE: begin
                if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = c_REST_LD;
                end
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    irrig_tick_timer #(
        .W (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_tick     (tick),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Dose sequencer: outputs are updated on the transition edges so that
    // valve, pump and busy come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_valve       <= '0;
            r_pump        <= 1'b0;
            r_busy        <= 1'b0;
            r_area        <= 1'b0;
            r_last_served <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state <= ST_PRIME;
                        r_area  <= w_sel;
                        r_valve <= area_onehot(w_sel);
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (w_done) begin
                        r_state <= ST_WATER;
                        r_pump  <= 1'b1;
                    end
                end
                ST_WATER: begin
                    if (w_done) begin
                        r_state <= ST_CLOSE;
                        r_pump  <= 1'b0;
                    end
                end
                ST_CLOSE: begin
                    if (w_done) begin
                        r_state       <= ST_REST;
                        r_valve       <= '0;
                        r_last_served <= r_area;
                    end
                end
                ST_REST: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valve <= '0;
                    r_pump  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRRIG_FAULT_EN
    // Dose counters are at least 3 bits wide and always hold MAX_DOSES.
    localparam int c_DOSE_CW = $clog2(MAX_DOSES + 1);
    localparam int c_DOSE_W  = (c_DOSE_CW > 3) ? c_DOSE_CW : 3;
    localparam logic [c_DOSE_W-1:0] c_MAX_DOSES = c_DOSE_W'(MAX_DOSES);

    logic w_rest_entry;
    logic w_idle;

    assign w_rest_entry = (r_state == ST_CLOSE) && w_done;
    assign w_idle       = (r_state == ST_IDLE);

    for (genvar gi = 0; gi < N_AREAS; gi++) begin : g_area_fault
        logic [c_DOSE_W-1:0] r_doses;
        logic                r_fault;

        // Count consecutive doses; a not-dry reading in IDLE restarts the
        // run, and reaching the limit latches the area's fault until reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_doses <= '0;
                r_fault <= 1'b0;
            end else if (w_rest_entry && (r_area == area_t'(gi))) begin
                if (r_doses != c_MAX_DOSES) begin
                    r_doses <= r_doses + 1'b1;
                end
                if (r_doses == (c_MAX_DOSES - 1'b1)) begin
                    r_fault <= 1'b1;
                end
            end else if (w_idle && !dry[gi]) begin
                r_doses <= '0;
            end
        end

        assign w_fault[gi] = r_fault;
    end

    assign w_elig = dry & ~w_fault;
`else
    assign w_fault = '0;
    assign w_elig  = dry;
`endif

    assign valve = r_valve;
    assign pump  = r_pump;
    assign busy  = r_busy;
    assign area  = r_area;
    assign fault = w_fault;

endmodule : irrigation_sequencer
`default_nettype wire

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Sequential valve and pump controller that sits directly downstream of the irrigation sensor-decode stage. It consumes the 2-bit per-area dry flags and waters at most one area at a time through a timed sequence: open valve, start pump, stop pump, close valve, rest. The sequence runs on a slow tick strobe. Two dry areas are served round-robin.

## Interface
Parameters:
- PRIME_TICKS, default 2: ticks the valve is open before the pump starts (≥1)
- WATER_TICKS, default 5: ticks with pump on (≥1)
- REST_TICKS, default 3: ticks with everything off after a dose (≥1)
- MAX_DOSES, default 4: consecutive doses to one area before a fault (only with IRRIG_FAULT_EN)

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timebase strobe, synchronous to clk
- dry  in  2  per-area low-moisture flags from the sensor-decode stage; bit0 = area 0, bit1 = area 1
- valve  out  2  one-hot-or-zero valve drive; bit i opens area i
- pump  out  1  pump drive
- busy  out  1  high in any state other than IDLE
- area  out  1  index of the area being served; holds its last value in IDLE
- fault  out  2  per-area fault latch (tied to 0 without IRRIG_FAULT_EN)

## Operation
- States: IDLE, PRIME, WATER, CLOSE, REST.
- IDLE: all outputs low. On any clk edge with dry≠0, select an area and go to PRIME. This does not wait for tick.
- Selection: if exactly one eligible bit is set, take it. If both are set, take the area other than last_served. last_served resets to 1, so area 0 wins the first tie.
- PRIME: valve[area]=1, pump=0 for PRIME_TICKS ticks.
- WATER: valve[area]=1, pump=1 for WATER_TICKS ticks.
- CLOSE: valve[area]=1, pump=0 for exactly 1 tick.
- REST: valve=0, pump=0 for REST_TICKS ticks, then go to IDLE. last_served takes the value of area on REST entry.
- dry is sampled only at the IDLE→PRIME decision. Changes to dry during a dose are ignored, so a dose always runs to completion.
- Invariants:
  - pump=1 implies exactly one valve bit is 1.
  - valve is never 2'b11.
  - pump is never 1 outside WATER.
- Timer: a down-counter, width $clog2(max parameter + 1). It is loaded with the parameter value minus 1 on state entry and decremented on tick. The state advances on the tick edge where the counter is 0.
- Reset is asynchronous from any state:
  - immediate IDLE, valve=0, pump=0, busy=0, area=0
  - last_served=1, fault=0, timers cleared

## Timing
- All outputs are registered and change only on clk rising edges, or immediately on rst_n assertion.
- IDLE→PRIME: the edge after dry≠0 is first seen, so busy and the valve rise 1 clk after dry.
- The dose length is exact in ticks: PRIME_TICKS + WATER_TICKS + 1 + REST_TICKS.
  - The first state's duration is measured from entry to its first tick. The entry-to-first-tick fraction counts as zero.
- A tick coincident with the IDLE→PRIME transition does not count toward PRIME.
- Back-to-back service: REST→IDLE, then one clk later →PRIME if dry≠0. There is a minimum 1 clk IDLE gap.
- tick held high for multiple cycles counts once per cycle. Callers must supply single-cycle strobes.

## Configuration
- IRRIG_FAULT_EN defined:
  - A per-area 3-bit-or-wider consecutive-dose counter increments on REST entry for the served area.
  - The counter clears when that area is found not dry at an IDLE decision.
  - When the count reaches MAX_DOSES, fault[area] latches high until reset.
  - A faulted area is ineligible for selection, i.e. its dry bit is masked.
- IRRIG_FAULT_EN undefined:
  - No counters.
  - fault is constant 2'b00.
  - Selection uses dry unmasked.

## Structure
- Package irrig_pkg:
  - state enum irrig_state_t
  - typedef area_t (1 bit)
  - localparam N_AREAS = 2
- Sub-module irrig_tick_timer:
  - loadable down-counter with tick enable
  - outputs done = (count==0 && tick)
  - one instance, shared across states

## Test plan
- Reset mid-WATER (pump=1): assert rst_n=0 → valve=0, pump=0, busy=0 in the same cycle, with no clk needed.
- dry=01, defaults, tick every 4 clk → valve=01 for 8 ticks, with pump=1 exactly during ticks 3–7. valve=00 for 3 ticks, then IDLE.
- dry=11 held → doses alternate area 0,1,0,1. valve is never 11, and pump is never high with valve=00.
- dry=10, then dry dropped to 00 during WATER → the dose still completes the full WATER + CLOSE + REST, then stays IDLE.
- tick coincident with the IDLE→PRIME edge → PRIME still lasts 2 full ticks after entry.
- IRRIG_FAULT_EN, MAX_DOSES=4, dry=01 held → after the 4th REST entry fault=01 and the sequencer stays IDLE. With dry=11, only area 1 is served thereafter.
